ptx_110110: RTL
===============

Name: ptx_110110

Overview:
- Serial frame transmitter. It is the source end of the bit-serial link whose receiver detects the sync pattern 110110.
- Accepts a parallel payload word on a valid/ready handshake. Emits the 6-bit sync header 110110 followed by the payload, one bit per cycle on data_o, qualified by valid_o.
- Drives the pattern detector in loopback benches and on-chip links.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- PAT_W, 6, sync header width.
- PATTERN, 6'b110110, sync header value, transmitted MSB first.

Ports:
- clk_i  input  1  clock, all logic on rising edge
- rst_ni  input  1  synchronous active-low reset
- data_i  input  DATA_W  payload word
- valid_i  input  1  payload word valid
- ready_o  output  1  block can accept a word this cycle
- hold_i  input  1  pause transmission; no bit is emitted while high
- data_o  output  1  serial bit
- valid_o  output  1  data_o carries a frame bit this cycle
- busy_o  output  1  frame in progress (SYNC or DATA state)
- done_o  output  1  one-cycle pulse coincident with the last frame bit

Behaviour:
- Reset: synchronous; rst_ni sampled low at a clock edge.
  - After that edge: state=S_IDLE, data_o=0, valid_o=0, busy_o=0, done_o=0, shift register and counters cleared.
  - ready_o = (state==S_IDLE) & ~hold_i & rst_ni. It is therefore 0 during any reset cycle.
  - Reset mid-frame aborts the frame; no partial bits follow and done_o does not pulse.
- FSM states: S_IDLE, S_SYNC, S_DATA (S_PAR only with the option).
  - S_IDLE: on valid_i & ready_o, latch data_i into the shift register, clear the bit counter, go to S_SYNC.
  - S_SYNC: emit PATTERN[PAT_W-1-cnt]. After the PAT_W-th emitted bit go to S_DATA with the counter cleared.
  - S_DATA: emit shift MSB, shift left. After the DATA_W-th bit go to S_IDLE (or S_PAR).
- Output registration: data_o, valid_o, busy_o and done_o are registered.
  - Handshake at edge T means the first sync bit is visible in the cycle after T (latency 1).
  - A frame is PAT_W+DATA_W consecutive valid_o cycles when hold_i stays low.
- hold_i, sampled each cycle:
  - While high in S_SYNC or S_DATA: the next cycle has valid_o=0 and data_o holds its previous value. Counter and shift register do not advance, busy_o stays 1.
  - Bits resume exactly where they stopped; no bit is lost or duplicated.
  - hold_i high in S_IDLE blocks acceptance.
- Frame spacing: ready_o is 0 outside S_IDLE, so valid_i during a frame is ignored and not queued. Back-to-back frames therefore have exactly one valid_o=0 cycle between them (the S_IDLE acceptance cycle).
- done_o: 1 in the same cycle as the final valid bit. It is never asserted on a valid_o=0 cycle.
- Counter: $clog2(max(PAT_W,DATA_W)+1) bits, no wrap within a frame.
- Payload is not escaped. A payload containing 110110, or a payload bit sequence that completes the pattern together with the header tail, causes extra detections at the receiver. This is by design.

Optional Feature:
- Macro PTX_PARITY_EN.
- Defined:
  - After the last payload bit, state S_PAR emits one even-parity bit (XOR of the latched payload).
  - Frame length is PAT_W+DATA_W+1, and done_o moves to the parity bit.
  - hold_i applies to S_PAR as to the other bit states.
- Undefined: S_PAR, the parity logic and the state encoding slot are absent; the frame is PAT_W+DATA_W bits.

Decomposition:
- Shared package ptx_pkg:
  - state enum (S_IDLE, S_SYNC, S_DATA, S_PAR)
  - SYNC_PATTERN = 6'b110110 and SYNC_W = 6, also imported by the detector side
  - frame_len function (PAT_W+DATA_W[+1])
- Sub-module ptx_shift: loadable MSB-first shift register with advance enable (load, advance, msb). The FSM and counters stay in ptx_110110.

Test Plan:
- Single frame, DATA_W=8, data_i=8'hA5 at edge T:
  - Cycles T+1..T+14 give valid_o=1, data_o = 1,1,0,1,1,0,1,0,1,0,0,1,0,1.
  - done_o=1 only at T+14; busy_o=1 for T+1..T+14.
  - ready_o=0 from T+1 until S_IDLE is re-entered.
- hold_i high for 3 cycles starting after bit 4 of 8'h3C:
  - Those 3 cycles have valid_o=0 with data_o holding bit 4.
  - The collected valid bits equal 110110_00111100; done_o is delayed by 3 cycles.
- Back-to-back, valid_i held high with 8'hFF then 8'h00: two 14-bit frames separated by exactly one valid_o=0 cycle; 8'h00 is not accepted until 8'hFF completes.
- Reset (rst_ni=0 for 1 cycle) during payload bit 3:
  - Next cycle valid_o=0, busy_o=0, done_o=0.
  - A new 8'h81 frame after reset starts cleanly with 110110.
- Loopback into the 110110 detector (valid_o→valid_i, data_o→data_i) with payload 8'h00: detector pulses exactly once per frame, at the 6th sync bit; no false detections.
- PTX_PARITY_EN defined:
  - 8'hA5 → 15 bits ending in parity 0.
  - 8'hA4 → parity bit 1.
  - done_o on bit 15 in both cases.

Source files
------------

// File: rtl/ptx_pkg.sv
// Shared definitions for the 110110 sync-framed serial link.
// States, sync header and frame length; parity slot via PTX_PARITY_EN.
package ptx_pkg;

  localparam int SYNC_W = 6;
  localparam logic [SYNC_W-1:0] SYNC_PATTERN = 6'b110110;

`ifdef PTX_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_PAR
  } state_e;
  localparam int PAR_W = 1;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_DATA
  } state_e;
  localparam int PAR_W = 0;
`endif

  function automatic int frame_len(
    input int pat_w,
    input int data_w
  );
    return pat_w + data_w + PAR_W;
  endfunction

endpackage

// File: rtl/ptx_110110_shift.sv
// Loadable MSB-first payload shift register with advance enable.
// Load wins over advance; zeros are shifted in at the LSB.
module ptx_110110_shift #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         i_load,
  input  logic         i_adv,
  input  logic [W-1:0] i_data,
  output logic         o_msb
);

  logic [W-1:0] r_sh;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_sh <= '0;
    end else if (i_load) begin
      r_sh <= i_data;
    end else if (i_adv) begin
      r_sh <= r_sh << 1;
    end
  end

  assign o_msb = r_sh[W-1];

endmodule

// File: rtl/ptx_110110.sv
// Serial frame transmitter: sync header 110110 then payload, MSB first.
// Define PTX_PARITY_EN to append an even-parity bit to every frame.
module ptx_110110
  import ptx_pkg::*;
#(
  parameter int                 DATA_W  = 8,
  parameter int                 PAT_W   = SYNC_W,
  parameter logic [PAT_W-1:0]   PATTERN = SYNC_PATTERN
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              hold_i,
  output logic              data_o,
  output logic              valid_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int MAXW = (PAT_W > DATA_W) ? PAT_W : DATA_W;
  localparam int CW   = $clog2(MAXW + 1);
  localparam logic [CW-1:0] SYNC_LAST = CW'(PAT_W - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);

  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  logic [PAT_W-1:0] w_pat;
  logic             w_acc;
  logic             w_adv;
  logic             w_msb;
`ifdef PTX_PARITY_EN
  logic             r_par;
`endif

  assign ready_o = (r_state == S_IDLE) & ~hold_i & rst_ni;
  assign w_acc   = valid_i & ready_o;
  assign w_pat   = PATTERN << r_cnt;
  assign w_adv   = (r_state == S_DATA) & ~hold_i & ~done_o;

  ptx_110110_shift #(
    .W(DATA_W)
  ) u_shift (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .i_load(w_acc),
    .i_adv (w_adv),
    .i_data(data_i),
    .o_msb (w_msb)
  );

  // The first header bit is launched on the acceptance edge, so the
  // counter records how many header bits are already on the wire.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      data_o  <= 1'b0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
`ifdef PTX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else if (r_state != S_IDLE && done_o) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else if (r_state != S_IDLE && hold_i) begin
      valid_o <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_state <= S_SYNC;
            r_cnt   <= CW'(1);
            data_o  <= PATTERN[PAT_W-1];
            valid_o <= 1'b1;
            busy_o  <= 1'b1;
`ifdef PTX_PARITY_EN
            r_par   <= ^data_i;
`endif
          end
        end
        S_SYNC: begin
          data_o  <= w_pat[PAT_W-1];
          valid_o <= 1'b1;
          if (r_cnt == SYNC_LAST) begin
            r_state <= S_DATA;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          data_o  <= w_msb;
          valid_o <= 1'b1;
          if (r_cnt == DATA_LAST) begin
            r_cnt <= '0;
`ifdef PTX_PARITY_EN
            r_state <= S_PAR;
`else
            done_o  <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef PTX_PARITY_EN
        S_PAR: begin
          data_o  <= r_par;
          valid_o <= 1'b1;
          done_o  <= 1'b1;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
